// File: rtl/input_debounce.sv
// Synchronizes and debounces DE10-Standard keys/switches for the audio_system PIOs.
// Optional switch debouncing is enabled by defining INPUT_DEBOUNCE_SW_EN.
module input_debounce #(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [N_KEYS-1:0] key_n,
    input  logic [N_SW-1:0]   sw,
    output logic [31:0]       key_external_export,
    output logic [31:0]       switch_external_export,
    output logic [N_KEYS-1:0] key_press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [N_SW-1:0]   sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [N_KEYS-1:0] key_lvl;
    logic [N_KEYS-1:0] key_stab;
    logic [N_SW-1:0]   sw_stab;

    always_comb begin
        key_s1_d = key_n;
        key_s2_d = key_s1_q;
        sw_s1_d  = sw;
        sw_s2_d  = sw_s1_q;
    end

    // Synchronizers reset to the "released" raw level of each input kind.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            key_s1_q <= '1;
            key_s2_q <= '1;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            key_s1_q <= key_s1_d;
            key_s2_q <= key_s2_d;
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
        end
    end

    assign key_lvl = ~key_s2_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic [CW-1:0] cnt_q, cnt_d;
            logic          stab_q, stab_d;
            logic          pulse_q, pulse_d;

            // Any sample matching the accepted level restarts the count.
            always_comb begin
                cnt_d  = cnt_q;
                stab_d = stab_q;
                if (key_lvl[gi] == stab_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    stab_d = key_lvl[gi];
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                pulse_d = stab_d & ~stab_q;
            end

            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    cnt_q   <= '0;
                    stab_q  <= 1'b0;
                    pulse_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    stab_q  <= stab_d;
                    pulse_q <= pulse_d;
                end
            end

            assign key_stab[gi]        = stab_q;
            assign key_press_pulse[gi] = pulse_q;
        end
    endgenerate

`ifdef INPUT_DEBOUNCE_SW_EN
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_sw
            logic [CW-1:0] cnt_q, cnt_d;
            logic          stab_q, stab_d;

            always_comb begin
                cnt_d  = cnt_q;
                stab_d = stab_q;
                if (sw_s2_q[gi] == stab_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    stab_d = sw_s2_q[gi];
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    cnt_q  <= '0;
                    stab_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    stab_q <= stab_d;
                end
            end

            assign sw_stab[gi] = stab_q;
        end
    endgenerate
`else
    assign sw_stab = sw_s2_q;
`endif

    always_comb begin
        key_external_export                = '0;
        key_external_export[N_KEYS-1:0]    = key_stab;
        switch_external_export             = '0;
        switch_external_export[N_SW-1:0]   = sw_stab;
    end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce (DEBOUNCE_CYCLES=8): expected output changes are
// queued with their cycle when stimulus is driven and matched by a negedge monitor.
module tb_input_debounce;

    localparam int D = 8;
    localparam int KEY_LAT = D + 2;
`ifdef INPUT_DEBOUNCE_SW_EN
    localparam int SW_LAT = D + 2;
`else
    localparam int SW_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_reset;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic [31:0] key_ext;
    logic [31:0] sw_ext;
    logic [3:0]  pulse;

    input_debounce #(
        .N_KEYS(4),
        .N_SW(10),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk_clk(clk),
        .reset_reset(reset_reset),
        .key_n(key_n),
        .sw(sw),
        .key_external_export(key_ext),
        .switch_external_export(sw_ext),
        .key_press_pulse(pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [31:0] key;
        logic [3:0]  pls;
        logic [31:0] swv;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  mon_en   = 1'b0;
    logic [31:0] prev_key = '0;
    logic [31:0] prev_sw  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
            $display("cyc %0d check %s observed=%h expected=%h ok", cyc, tag, obs, expv);
        end else begin
            $error("FAIL %s observed=%h expected=%h (cyc %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push(input int at, input logic [31:0] k, input logic [3:0] p, input logic [31:0] s);
        ev_t e;
        e.at = at; e.key = k; e.pls = p; e.swv = s;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Any visible output activity must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en && (key_ext !== prev_key || pulse !== 4'b0 || sw_ext !== prev_sw)) begin
            if (exp_q.size() == 0) begin
                chk("spurious_key", key_ext, prev_key);
                chk("spurious_pulse", {28'b0, pulse}, 32'b0);
                chk("spurious_sw", sw_ext, prev_sw);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event_cycle", 32'(cyc), 32'(e.at));
                chk("event_key", key_ext, e.key);
                chk("event_pulse", {28'b0, pulse}, {28'b0, e.pls});
                chk("event_sw", sw_ext, e.swv);
            end
        end
        if (mon_en) begin
            prev_key = key_ext;
            prev_sw  = sw_ext;
        end
    end

    initial begin
        int c;
        int r;
        key_n       = 4'hF;
        sw          = '0;
        reset_reset = 1'b1;
        tick(3);
        chk("reset_key", key_ext, 32'h0);
        chk("reset_sw", sw_ext, 32'h0);
        chk("reset_pulse", {28'b0, pulse}, 32'h0);
        mon_en      = 1'b1;
        reset_reset = 1'b0;
        tick(2);

        // Clean press of key 0
        key_n[0] = 1'b0;
        push(cyc + KEY_LAT, 32'h1, 4'b0001, 32'h0);
        tick(20);

        // Bounce on key 1 never accepted, then a clean hold
        key_n[1] = 1'b0; tick(5);
        key_n[1] = 1'b1; tick(1);
        key_n[1] = 1'b0; tick(5);
        key_n[1] = 1'b1; tick(1);
        chk("bounce_key", key_ext, 32'h1);
        chk("bounce_pulse", {28'b0, pulse}, 32'h0);
        key_n[1] = 1'b0;
        push(cyc + KEY_LAT, 32'h3, 4'b0010, 32'h0);
        tick(20);

        // Release keys 0 and 1: no pulse
        key_n[1:0] = 2'b11;
        push(cyc + KEY_LAT, 32'h0, 4'b0000, 32'h0);
        tick(20);

        // Reset while key 2 count is at 5
        key_n[2] = 1'b0;
        c = cyc;
        tick(7);
        chk("midcount_key", key_ext, 32'h0);
        reset_reset = 1'b1;
        tick(1);
        chk("reset_edge_key", key_ext, 32'h0);
        chk("reset_edge_pulse", {28'b0, pulse}, 32'h0);
        reset_reset = 1'b0;
        push(c + 8 + KEY_LAT, 32'h4, 4'b0100, 32'h0);
        tick(20);
        key_n[2] = 1'b1;
        push(cyc + KEY_LAT, 32'h0, 4'b0000, 32'h0);
        tick(20);

        // Simultaneous press of keys 3 and 0
        key_n = 4'b0110;
        push(cyc + KEY_LAT, 32'h9, 4'b1001, 32'h0);
        tick(20);
        key_n = 4'hF;
        push(cyc + KEY_LAT, 32'h0, 4'b0000, 32'h0);
        tick(20);

        // Switches, including a switch held up through reset
        sw = 10'h2A5;
        push(cyc + SW_LAT, 32'h0, 4'b0000, 32'h2A5);
        tick(20);
        reset_reset = 1'b1;
        r = cyc + 1;
        push(r, 32'h0, 4'b0000, 32'h0);
        tick(1);
        reset_reset = 1'b0;
        push(r + SW_LAT, 32'h0, 4'b0000, 32'h2A5);
        tick(20);
        sw = 10'h15A;
        push(cyc + SW_LAT, 32'h0, 4'b0000, 32'h15A);
        tick(20);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
